// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
//   N_REQ  : number of requesters
//   OP_W   : signed operand width
//   RES_W  : signed product width
//   state_t: arbiter FSM encoding
//   op_mag : two's-complement magnitude; -32768 maps to 32768 unsigned
package mul_arbiter_pkg;

  localparam int N_REQ = 2;
  localparam int OP_W  = 16;
  localparam int RES_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // The most negative value negates to itself, which read back as unsigned
  // is exactly its magnitude, so no special case is needed.
  function automatic logic [OP_W-1:0] op_mag(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? (~v + OP_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_arbiter_mul.sv
// Iterative 16x16 unsigned shift-add multiplier.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands and begin (also restarts a running operation)
//   in_a, in_b : unsigned operands sampled with start
//   out        : product, valid once busy falls
//   busy       : high while iterating, one cycle per multiplier bit
module mul_arbiter_mul
  import mul_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic [RES_W-1:0] out,
  output logic             busy
);

  localparam int CNT_W = $clog2(OP_W + 1);

  logic [RES_W-1:0] acc_q;
  logic [RES_W-1:0] a_sh_q;
  logic [OP_W-1:0]  b_sh_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      a_sh_q <= RES_W'(in_a);
      b_sh_q <= in_b;
      cnt_q  <= CNT_W'(OP_W);
      busy   <= 1'b1;
    end else if (busy) begin
      if (b_sh_q[0]) acc_q <= acc_q + a_sh_q;
      a_sh_q <= a_sh_q << 1;
      b_sh_q <= b_sh_q >> 1;
      cnt_q  <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy <= 1'b0;
    end
  end

  assign out = acc_q;

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of one shared iterative multiplier.
// Operands are converted to sign/magnitude, multiplied unsigned, and the
// sign is re-applied on completion. A timer bounds each operation.
//   clk, rst_n       : clock, async active-low reset
//   req[1:0]         : request levels, bit i = requester i
//   in_a_i, in_b_i   : signed operands of requester i
//   gnt[1:0]         : one-hot pulse, operands of requester i captured
//   done[1:0]        : one-hot pulse, result valid for requester i
//   result           : signed product, held until the next done
//   err              : pulse when the multiplier does not finish in time
//
// state        | meaning
// IDLE         | arbitrate; capture winner operands on any request
// LAUNCH       | gnt pulse, start multiplier, timer running
// WAIT_BUSY    | wait for multiplier to report busy
// WAIT_DONE    | wait for busy to fall, then take the signed product
// RESP         | done pulse with result
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic signed [OP_W-1:0]  in_a_0,
  input  logic signed [OP_W-1:0]  in_b_0,
  input  logic signed [OP_W-1:0]  in_a_1,
  input  logic signed [OP_W-1:0]  in_b_1,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic signed [RES_W-1:0] result,
  output logic                    err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;

  logic                   win_q, win_sel;
  logic                   prio_q;
  logic                   sign_q;
  logic [OP_W-1:0]        mag_a_q, mag_b_q;
  logic [TMR_W-1:0]       tmr_q;
  logic                   err_q, expire;
  logic                   timing, timeout_hit;
  logic signed [OP_W-1:0] a_sel, b_sel;

  logic                   mul_start, mul_busy;
  logic [RES_W-1:0]       mul_out;

  // prio_q names the requester that wins a tie in round-robin mode.
  always_comb begin
    win_sel = 1'b0;
    if (req == 2'b10) win_sel = 1'b1;
    else if (req == 2'b11) win_sel = (ARB_MODE == 0) ? prio_q : 1'b0;
  end

  assign a_sel = win_sel ? in_a_1 : in_a_0;
  assign b_sel = win_sel ? in_b_1 : in_b_0;

  assign timing      = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_BUSY) ||
                       (state_q == ST_WAIT_DONE);
  assign timeout_hit = timing && (tmr_q == '0);

  always_comb begin
    state_d   = state_q;
    gnt       = '0;
    done      = '0;
    mul_start = 1'b0;
    expire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        gnt[win_q] = 1'b1;
        mul_start  = 1'b1;
        if (timeout_hit) begin
          state_d = ST_IDLE;
          expire  = 1'b1;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (timeout_hit) begin
          state_d = ST_IDLE;
          expire  = 1'b1;
        end else if (mul_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A completion on the final timer cycle still counts as in time.
        if (!mul_busy) begin
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          expire  = 1'b1;
        end
      end
      ST_RESP: begin
        done[win_q] = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      prio_q  <= 1'b0;
      sign_q  <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= expire;
      if ((state_q == ST_IDLE) && (req != '0)) begin
        win_q   <= win_sel;
        prio_q  <= ~win_sel;
        mag_a_q <= op_mag(a_sel);
        mag_b_q <= op_mag(b_sel);
        sign_q  <= a_sel[OP_W-1] ^ b_sel[OP_W-1];
        tmr_q   <= TMR_W'(TIMEOUT - 1);
      end else if (timing && (tmr_q != '0)) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end
      if ((state_q == ST_WAIT_DONE) && !mul_busy) begin
        result <= (sign_q && (mul_out != '0)) ? -$signed(mul_out) : $signed(mul_out);
      end
    end
  end

  assign err = err_q;

  mul_arbiter_mul u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .in_a  (mag_a_q),
    .in_b  (mag_b_q),
    .out   (mul_out),
    .busy  (mul_busy)
  );

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

  localparam int TO2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic [1:0] req0 = '0, req1 = '0, req2 = '0;
  logic signed [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0] gnt0, gnt1, gnt2, done0, done1, done2;
  logic signed [31:0] res0, res1, res2;
  logic err0, err1, err2;

  int n_cmp = 0;
  int n_bad = 0;

  mul_arbiter #(.ARB_MODE(0), .TIMEOUT(40)) d0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .in_a_0(a0), .in_b_0(b0),
    .in_a_1(a1), .in_b_1(b1), .gnt(gnt0), .done(done0), .result(res0), .err(err0));
  mul_arbiter #(.ARB_MODE(1), .TIMEOUT(40)) d1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .in_a_0(a0), .in_b_0(b0),
    .in_a_1(a1), .in_b_1(b1), .gnt(gnt1), .done(done1), .result(res1), .err(err1));
  mul_arbiter #(.ARB_MODE(0), .TIMEOUT(TO2)) d2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .in_a_0(a0), .in_b_0(b0),
    .in_a_1(a1), .in_b_1(b1), .gnt(gnt2), .done(done2), .result(res2), .err(err2));

  // Pulse exclusivity on every instance whenever anything is asserted.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (gnt0 != 0 || done0 != 0 || err0) begin
        n_cmp++;
        if ($countones(gnt0) > 1 || $countones(done0) > 1 ||
            (int'(gnt0 != 0) + int'(done0 != 0) + int'(err0)) > 1) begin
          n_bad++;
          $display("FAIL excl_d0 gnt=%b done=%b err=%b, required at most one one-hot pulse", gnt0, done0, err0);
        end
      end
      if (gnt1 != 0 || done1 != 0 || err1) begin
        n_cmp++;
        if ($countones(gnt1) > 1 || $countones(done1) > 1 ||
            (int'(gnt1 != 0) + int'(done1 != 0) + int'(err1)) > 1) begin
          n_bad++;
          $display("FAIL excl_d1 gnt=%b done=%b err=%b, required at most one one-hot pulse", gnt1, done1, err1);
        end
      end
      if (gnt2 != 0 || done2 != 0 || err2) begin
        n_cmp++;
        if ($countones(gnt2) > 1 || $countones(done2) > 1 ||
            (int'(gnt2 != 0) + int'(done2 != 0) + int'(err2)) > 1) begin
          n_bad++;
          $display("FAIL excl_d2 gnt=%b done=%b err=%b, required at most one one-hot pulse", gnt2, done2, err2);
        end
      end
    end
  end

  function automatic logic signed [31:0] prod(input logic signed [15:0] a, input logic signed [15:0] b);
    return 32'(longint'(a) * longint'(b));
  endfunction

  function automatic logic signed [15:0] pick_op();
    int s;
    s = $urandom_range(0, 9);
    case (s)
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic wait_gnt(input int which, output logic [1:0] g, output int lat);
    logic [1:0] v;
    g = '0;
    lat = -1;
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      @(negedge clk);
      v = (which == 0) ? gnt0 : (which == 1) ? gnt1 : gnt2;
      if (v != 0) begin
        g = v;
        lat = i;
      end
    end
  endtask

  task automatic wait_done(input int which, output logic [1:0] d, output logic signed [31:0] r,
                           output int lat, output int ne);
    logic [1:0] v;
    d = '0;
    r = '0;
    lat = -1;
    ne = 0;
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      @(negedge clk);
      v = (which == 0) ? done0 : (which == 1) ? done1 : done2;
      if (((which == 0) ? err0 : (which == 1) ? err1 : err2) == 1'b1) ne++;
      if (v != 0) begin
        d = v;
        r = (which == 0) ? res0 : (which == 1) ? res1 : res2;
        lat = i;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({gnt0, gnt1, gnt2} !== 6'b0) begin
      n_bad++; $display("FAIL reset_gnt got %b want 0", {gnt0, gnt1, gnt2});
    end
    n_cmp++;
    if ({done0, done1, done2} !== 6'b0) begin
      n_bad++; $display("FAIL reset_done got %b want 0", {done0, done1, done2});
    end
    n_cmp++;
    if ({err0, err1, err2} !== 3'b0) begin
      n_bad++; $display("FAIL reset_err got %b want 0", {err0, err1, err2});
    end
    n_cmp++;
    if (res0 !== 32'sd0 || res1 !== 32'sd0 || res2 !== 32'sd0) begin
      n_bad++; $display("FAIL reset_result got %0d/%0d/%0d want 0", res0, res1, res2);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0] g, d;
    logic signed [31:0] r;
    int lat, dl, ne;
    // first request right at reset release: granted one cycle later
    a0 = 16'sd9205; b0 = 16'sd3242; req0 = 2'b01;
    wait_gnt(0, g, lat);
    n_cmp++;
    if (g !== 2'b01 || lat != 1) begin
      n_bad++; $display("FAIL dir_gnt0 got gnt=%b lat=%0d want 01 lat=1", g, lat);
    end
    req0 = 2'b00; a0 = 16'($urandom); b0 = 16'($urandom);
    wait_done(0, d, r, dl, ne);
    n_cmp++;
    if (d !== 2'b01 || r !== 32'sd29842610 || ne != 0 || dl < 2 || dl > 40) begin
      n_bad++; $display("FAIL dir_pos got done=%b res=%0d err=%0d lat=%0d want 01 29842610 0", d, r, ne, dl);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (res0 !== 32'sd29842610 || done0 !== 2'b00) begin
      n_bad++; $display("FAIL dir_hold got res=%0d done=%b want 29842610 00", res0, done0);
    end

    a1 = -16'sd9205; b1 = 16'sd3242; req0 = 2'b10;
    wait_gnt(0, g, lat);
    n_cmp++;
    if (g !== 2'b10 || lat != 1) begin
      n_bad++; $display("FAIL dir_gnt1 got gnt=%b lat=%0d want 10 lat=1", g, lat);
    end
    req0 = 2'b00;
    wait_done(0, d, r, dl, ne);
    n_cmp++;
    if (d !== 2'b10 || r !== -32'sd29842610 || ne != 0) begin
      n_bad++; $display("FAIL dir_neg got done=%b res=%0d err=%0d want 10 -29842610 0", d, r, ne);
    end
    @(negedge clk);

    a1 = 16'h8000; b1 = 16'h8000; req0 = 2'b10;
    wait_gnt(0, g, lat);
    req0 = 2'b00;
    wait_done(0, d, r, dl, ne);
    n_cmp++;
    if (d !== 2'b10 || r !== 32'sd1073741824) begin
      n_bad++; $display("FAIL dir_full got done=%b res=%0d want 10 1073741824", d, r);
    end
    @(negedge clk);

    a0 = 16'sd0; b0 = -16'sd5; req0 = 2'b01;
    wait_gnt(0, g, lat);
    req0 = 2'b00;
    wait_done(0, d, r, dl, ne);
    n_cmp++;
    if (d !== 2'b01 || r !== 32'sd0) begin
      n_bad++; $display("FAIL dir_zero got done=%b res=%0d want 01 0", d, r);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g, d, eg;
    logic signed [31:0] r, e;
    int lat, dl, ne, last, w;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    a0 = 16'sd1111; b0 = -16'sd23; a1 = -16'sd4567; b1 = -16'sd89;
    req0 = 2'b11;
    last = 1;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(0, g, lat);
      w = (last == 0) ? 1 : 0;
      eg = (w == 1) ? 2'b10 : 2'b01;
      e = (w == 1) ? prod(a1, b1) : prod(a0, b0);
      last = w;
      if (k == 2) req0 = 2'b00;
      n_cmp++;
      if (g !== eg) begin
        n_bad++; $display("FAIL rr_gnt%0d got %b want %b", k, g, eg);
      end
      wait_done(0, d, r, dl, ne);
      n_cmp++;
      if (d !== eg || r !== e) begin
        n_bad++; $display("FAIL rr_done%0d got done=%b res=%0d want %b %0d", k, d, r, eg, e);
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] g, d;
    logic signed [31:0] r;
    int lat, dl, ne;
    @(negedge clk);
    a0 = 16'sd300; b0 = 16'sd7; a1 = -16'sd12; b1 = 16'sd1000;
    req1 = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(1, g, lat);
      if (k == 2) req1 = 2'b10;
      n_cmp++;
      if (g !== 2'b01) begin
        n_bad++; $display("FAIL fp_gnt%0d got %b want 01", k, g);
      end
      wait_done(1, d, r, dl, ne);
      n_cmp++;
      if (d !== 2'b01 || r !== 32'sd2100) begin
        n_bad++; $display("FAIL fp_done%0d got done=%b res=%0d want 01 2100", k, d, r);
      end
    end
    wait_gnt(1, g, lat);
    req1 = 2'b00;
    n_cmp++;
    if (g !== 2'b10) begin
      n_bad++; $display("FAIL fp_gnt_r1 got %b want 10", g);
    end
    wait_done(1, d, r, dl, ne);
    n_cmp++;
    if (d !== 2'b10 || r !== -32'sd12000) begin
      n_bad++; $display("FAIL fp_done_r1 got done=%b res=%0d want 10 -12000", d, r);
    end
  endtask

  task automatic test_withdraw();
    logic [1:0] g, d;
    logic signed [31:0] r;
    int lat, dl, ne, n_g;
    @(negedge clk);
    a0 = 16'sd5; b0 = 16'sd6; req0 = 2'b01;
    wait_gnt(0, g, lat);
    a1 = 16'sd77; b1 = 16'sd77; req0 = 2'b10;
    repeat (3) @(negedge clk);
    req0 = 2'b00;
    wait_done(0, d, r, dl, ne);
    n_cmp++;
    if (d !== 2'b01 || r !== 32'sd30) begin
      n_bad++; $display("FAIL wd_done got done=%b res=%0d want 01 30", d, r);
    end
    n_g = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt0 != 0) n_g++;
    end
    n_cmp++;
    if (n_g != 0) begin
      n_bad++; $display("FAIL wd_nogrant got %0d grants want 0", n_g);
    end
  endtask

  task automatic test_random();
    logic [1:0] g, d, eg;
    logic signed [31:0] r, e;
    int lat, dl, ne, last, w;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    last = 1;
    for (int it = 0; it < 40; it++) begin
      if (req0 == 2'b00) begin
        a0 = pick_op(); b0 = pick_op(); a1 = pick_op(); b1 = pick_op();
        req0 = 2'($urandom_range(1, 3));
      end
      wait_gnt(0, g, lat);
      if (req0 == 2'b11) w = (last == 0) ? 1 : 0;
      else w = (req0 == 2'b10) ? 1 : 0;
      last = w;
      eg = (w == 1) ? 2'b10 : 2'b01;
      e = (w == 1) ? prod(a1, b1) : prod(a0, b0);
      n_cmp++;
      if (g !== eg) begin
        n_bad++; $display("FAIL rnd_gnt it=%0d req=%b got %b want %b", it, req0, g, eg);
      end
      // drop the granted request, scramble its operands, maybe queue new ones
      if (w == 1) begin
        req0[1] = 1'b0; a1 = pick_op(); b1 = pick_op();
      end else begin
        req0[0] = 1'b0; a0 = pick_op(); b0 = pick_op();
      end
      if (!req0[0] && $urandom_range(0, 9) < 4) begin
        a0 = pick_op(); b0 = pick_op(); req0[0] = 1'b1;
      end
      if (!req0[1] && $urandom_range(0, 9) < 4) begin
        a1 = pick_op(); b1 = pick_op(); req0[1] = 1'b1;
      end
      wait_done(0, d, r, dl, ne);
      n_cmp++;
      if (d !== eg || r !== e || ne != 0) begin
        n_bad++; $display("FAIL rnd_done it=%0d got done=%b res=%0d err=%0d want %b %0d 0", it, d, r, ne, eg, e);
      end
    end
    req0 = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    logic [1:0] g, d;
    logic signed [31:0] r;
    int lat, dl, ne, n_d;
    repeat (2) @(negedge clk);
    a0 = 16'sd1234; b0 = -16'sd77; req0 = 2'b01;
    wait_gnt(0, g, lat);
    req0 = 2'b00;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt0 !== 2'b00 || done0 !== 2'b00 || err0 !== 1'b0 || res0 !== 32'sd0) begin
      n_bad++; $display("FAIL rmid_zero got gnt=%b done=%b err=%b res=%0d want all 0", gnt0, done0, err0, res0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_d = 0;
    repeat (30) begin
      @(negedge clk);
      if (done0 != 0 || err0) n_d++;
    end
    n_cmp++;
    if (n_d != 0) begin
      n_bad++; $display("FAIL rmid_nodone got %0d done/err pulses want 0", n_d);
    end
    a0 = -16'sd300; b0 = -16'sd400; req0 = 2'b01;
    wait_gnt(0, g, lat);
    req0 = 2'b00;
    n_cmp++;
    if (g !== 2'b01 || lat != 1) begin
      n_bad++; $display("FAIL rmid_gnt got gnt=%b lat=%0d want 01 1", g, lat);
    end
    wait_done(0, d, r, dl, ne);
    n_cmp++;
    if (d !== 2'b01 || r !== 32'sd120000) begin
      n_bad++; $display("FAIL rmid_done got done=%b res=%0d want 01 120000", d, r);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] g;
    logic signed [31:0] rb;
    int lat, elat, n_d;
    @(negedge clk);
    rb = res2;
    a0 = 16'sd100; b0 = 16'sd200; req2 = 2'b01;
    wait_gnt(2, g, lat);
    req2 = 2'b00;
    n_cmp++;
    if (g !== 2'b01 || lat != 1) begin
      n_bad++; $display("FAIL to_gnt got gnt=%b lat=%0d want 01 1", g, lat);
    end
    elat = -1; n_d = 0;
    for (int i = 1; i <= 40 && elat < 0; i++) begin
      @(negedge clk);
      if (done2 != 0) n_d++;
      if (err2) elat = i;
    end
    n_cmp++;
    if (elat != TO2) begin
      n_bad++; $display("FAIL to_err_lat got %0d want %0d", elat, TO2);
    end
    n_cmp++;
    if (n_d != 0 || res2 !== rb) begin
      n_bad++; $display("FAIL to_nodone got done_pulses=%0d res=%0d want 0 %0d", n_d, res2, rb);
    end
    req2 = 2'b01;
    @(negedge clk);
    n_cmp++;
    if (err2 !== 1'b0 || gnt2 !== 2'b01) begin
      n_bad++; $display("FAIL to_idle got err=%b gnt=%b want 0 01", err2, gnt2);
    end
    req2 = 2'b00;
    elat = -1;
    for (int i = 1; i <= 40 && elat < 0; i++) begin
      @(negedge clk);
      if (err2) elat = i;
    end
    n_cmp++;
    if (elat != TO2) begin
      n_bad++; $display("FAIL to_err_lat2 got %0d want %0d", elat, TO2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_fixed_priority();
    test_withdraw();
    test_random();
    test_reset_mid_op();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog got no completion want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority to requester 0.
REQ-002 Parameter TIMEOUT, default 40; maximum cycles from mul_start to multiplier completion.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 req  in  2  per-requester request level; bit i is requester i.
REQ-006 in_a_0, in_b_0  in  16  signed operands, requester 0.
REQ-007 in_a_1, in_b_1  in  16  signed operands, requester 1.
REQ-008 gnt  out  2  one-hot, one-cycle pulse; operands of requester i captured.
REQ-009 done  out  2  one-hot, one-cycle pulse; result valid for requester i.
REQ-010 result  out  32  signed product; valid in the done cycle, held until next done.
REQ-011 err  out  1  one-cycle pulse on multiplier timeout.

Function
REQ-012 States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP; encoding is shared-package constants.
REQ-013 IDLE, req != 0: select winner, capture its operands, go to LAUNCH; else stay.
REQ-014 ARB_MODE 0, both requests: grant the requester not granted last; pointer resets to favour requester 0.
REQ-015 ARB_MODE 1, both requests: always grant requester 0.
REQ-016 Captured magnitudes: |a|, |b| as unsigned 16 bit; sign flag = a[15] XOR b[15]; |-32768| = 32768.
REQ-017 LAUNCH, one cycle: gnt[winner]=1; mul_start=1 with the magnitudes on mul_in_a/mul_in_b; go to WAIT_BUSY.
REQ-018 WAIT_BUSY: mul_busy=1 moves to WAIT_DONE.
REQ-019 WAIT_DONE: mul_busy=0 captures mul_out, negates it when the sign flag is set and mul_out != 0, and moves to RESP.
REQ-020 RESP, one cycle: done[winner]=1, result driven; go to IDLE.
REQ-021 Timeout counter starts at LAUNCH. TIMEOUT cycles without reaching RESP: err=1 one cycle, result unchanged, no done, go to IDLE.
REQ-022 Latency: req seen in IDLE at edge T gives gnt high in T+1. done is high in the cycle after mul_busy is sampled low.
REQ-023 Requesters hold req and operands stable until gnt. Operand changes after gnt do not affect the operation.
REQ-024 req still high after its own done is a new request; arbitration applies again in IDLE.
REQ-025 A request arriving during a busy operation waits; it is never dropped.
REQ-026 A req deasserted before gnt is never granted.
REQ-027 gnt, done and err never assert in the same cycle; at most one bit of gnt and of done is set.
REQ-028 Full range: (-32768)*(-32768) = 1073741824 with no overflow; any operand 0 gives result 0 and never -0.

Reset
REQ-029 rst_n low: state=IDLE, gnt=0, done=0, err=0, result=0, mul_start=0, RR pointer=0, timeout counter=0, captured operands=0; all take effect immediately.
REQ-030 Reset mid-operation: the in-flight operation is discarded with no done. The multiplier receives the same rst_n.
REQ-031 First grant takes place at the earliest 1 cycle after rst_n deasserts.

Structure
REQ-032 Shared package holds: state encoding, N_REQ=2, operand width 16, result width 32.
REQ-033 One sub-module, mul: the existing 16x16 unsigned iterative multiplier (start, in_a, in_b, out, busy), instanced once inside.

Verification
REQ-034 req=01, in_a_0=9205, in_b_0=3242: gnt=01 one cycle later, then done=01 with result=29842610.
REQ-035 req=10, in_a_1=-9205, in_b_1=3242: result=-29842610. With -32768 * -32768: result=1073741824.
REQ-036 ARB_MODE=0, req=11 held for three operations, distinct operands: grant order 0,1,0; each result matches its requester.
REQ-037 ARB_MODE=1, req=11 held: every grant goes to requester 0; requester 1 waits until req[0] drops.
REQ-038 rst_n pulsed low during WAIT_DONE: outputs zero at once, no done. A fresh request afterwards completes correctly.
REQ-039 Stubbed multiplier holds busy high, TIMEOUT=40: err pulses 40 cycles after LAUNCH with no done, and the block returns to IDLE.
